// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller.
// One full_adder is reused for every bit position, LSB first. The carry
// flip-flop links one bit to the next. A registered result with carry-out
// and signed overflow is published on a one-cycle done pulse.

// One-bit full adder shared by all bit positions of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  // Holds the WIDTH-1 low result bits. The MSB comes straight from the
  // adder in the final cycle.
  logic [WIDTH-2:0] psum_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             c_out_reg;
  logic             overflow_reg;

  logic             accept;
  logic             last_bit;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] b_load;
  logic [WIDTH-1:0] psum_cat;

  // Subtraction is a + ~b + 1. Each B bit is inverted by sub, and the +1
  // comes in through the carry flip-flop.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_inv
      assign b_load[gi] = b[gi] ^ sub;
    end
  endgenerate

  full_adder u_fa (
    .a     (a_sh_reg[0]),
    .b     (b_sh_reg[0]),
    .c_in  (carry_reg),
    .s     (fa_s),
    .c_out (fa_c)
  );

  // The new bit enters at the top. After the last cycle the whole
  // concatenation is the result.
  assign psum_cat = {fa_s, psum_reg};
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and the accept strobe.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (last_bit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Serial datapath: operand load, one bit per cycle, result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_reg     <= '0;
      b_sh_reg     <= '0;
      psum_reg     <= '0;
      cnt_reg      <= '0;
      carry_reg    <= 1'b0;
      sum_reg      <= '0;
      c_out_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b_load;
      psum_reg  <= '0;
      cnt_reg   <= '0;
      carry_reg <= sub;
    end else if (state_reg == S_RUN) begin
      a_sh_reg  <= a_sh_reg >> 1;
      b_sh_reg  <= b_sh_reg >> 1;
      psum_reg  <= psum_cat[WIDTH-1:1];
      carry_reg <= fa_c;
      cnt_reg   <= cnt_reg + CW'(1);
      if (last_bit) begin
        sum_reg      <= psum_cat;
        c_out_reg    <= fa_c;
        // Signed overflow: the carry into the MSB differs from the carry out of it.
        overflow_reg <= carry_reg ^ fa_c;
      end
    end
  end

  assign busy     = (state_reg == S_RUN);
  assign done     = (state_reg == S_DONE);
  assign sum      = sum_reg;
  assign c_out    = c_out_reg;
  assign overflow = overflow_reg;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract controller that time-shares a single `full_adder` instance across all bits of a WIDTH-bit operation, one bit per clock, LSB first. It captures operands on a start handshake and sequences the adder through the carry chain via a carry flip-flop. It then publishes a registered result with carry-out and signed overflow. It sits between a requester (sequencer or ALU front end) and the one-bit adder datapath, trading latency for area.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE or DONE.
- `sub`  in  1  0 = a+b, 1 = a-b; sampled with `start`.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high while the serial operation is in progress.
- `done`  out  1  one-cycle pulse when `sum`/`c_out`/`overflow` update.
- `sum`  out  WIDTH  registered result.
- `c_out`  out  1  final carry out of the MSB; for subtract, 1 = no borrow.
- `overflow`  out  1  two's-complement signed overflow of the completed operation.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `busy`=0, `done`=0. If `start`=1, accept the request and go to RUN.
- Accept action:
  - Load shift register A with `a`.
  - Load shift register B with `b`, or with `~b` if `sub`=1.
  - Set the carry flip-flop to `sub`.
  - Clear the bit counter and the partial-sum shift register.
- RUN, once per cycle:
  - Drive the `full_adder` with A[0], B[0] and the carry flip-flop.
  - Shift the adder `s` into the MSB of the partial-sum register; the register shifts right.
  - Shift A and B right by one.
  - Load the carry flip-flop with the adder `c_out`.
  - Increment the counter.
- RUN exit: when the counter reaches WIDTH-1, the cycle completes the MSB and the FSM goes to DONE.
- Result capture, on the RUN->DONE edge:
  - `sum` gets the final partial sum.
  - `c_out` gets the adder carry out of the MSB.
  - `overflow` gets the carry into the MSB (carry flip-flop value in that cycle) XOR the carry out of the MSB.
- DONE: `done`=1 and `busy`=0 for exactly one cycle.
  - If `start`=1, accept a new request and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- `start` is ignored while in RUN: no queuing, and operands are not re-sampled.
- `sum`, `c_out` and `overflow` hold their values until the next DONE. They do not toggle during RUN.
- Exactly one `full_adder` instance; no other adders or incrementers on the data path. The counter increment is allowed.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `sum`=0, `c_out`=0, `overflow`=0. Carry flip-flop, counter and shift registers are cleared.
- `rst` has priority over `start` in the same cycle.
- `start` accepted at edge k:
  - `busy`=1 for cycles k+1 .. k+WIDTH.
  - `done`=1 in cycle k+WIDTH+1, with the result valid in that same cycle.
  - Latency from start to done is WIDTH+1 cycles.
- Back-to-back throughput: one result per WIDTH+1 cycles.
- `rst` asserted mid-RUN: the operation is aborted, no `done` is produced, and outputs return to their reset values on the next edge.
- `start` held high continuously: the block is accepted once in IDLE, then again in every DONE cycle.
- Arithmetic is modulo 2^WIDTH.
- Subtract: `c_out` = NOT borrow. `overflow` follows the signed rule for a + ~b + 1.

## Test plan
- WIDTH=8, `start` with a=100, b=27, sub=0 → `busy` high for 8 cycles; `done` at cycle 9 after start; `sum`=127, `c_out`=0, `overflow`=0.
- a=0xFF, b=0x01, sub=0 → `sum`=0x00, `c_out`=1, `overflow`=0. Then a=0x7F, b=0x01 → `sum`=0x80, `c_out`=0, `overflow`=1.
- sub=1: a=5, b=7 → `sum`=0xFE, `c_out`=0, `overflow`=0. Then a=0x80, b=0x01 → `sum`=0x7F, `c_out`=1, `overflow`=1.
- Pulse `start` with new operands at cycles 3 and 5 of a RUN → ignored. The original result is produced, `done` still lands at cycle 9, and the previous `sum` is held until then.
- Assert `rst` at RUN cycle 4 → no `done`; all outputs 0 next cycle. A fresh start afterward (a=1, b=2) yields `sum`=3.
- Hold `start`=1 with a=10, b=20, then change to a=3, b=4, sub=1 in the DONE cycle → first `done` has `sum`=30. The next operation begins the following cycle, and the second `done` arrives 9 cycles later with `sum`=0xFF, `c_out`=0.
